// File: rtl/regfile_dump.sv
// Purpose: halts the core, walks the register file and streams a framed snapshot (hdr, data LSB-first, checksum).
// Latency: halt_req one edge after start; header one edge after halted; one LOAD gap cycle before each register.
// Backpressure: tx_valid/tx_data held until tx_valid & tx_ready; tx_valid never depends on tx_ready.
module regfile_dump #(
    parameter int          NREGS    = 16,
    parameter int          DATA_W   = 32,
    parameter int          IDX_W    = 4,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              halt_req,
    input  logic              halted,
    output logic [IDX_W-1:0]  ra,
    input  logic [DATA_W-1:0] rd,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_HDR,
        S_LOAD,
        S_SEND,
        S_CSUM,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [7:0]         csum_q, csum_d;
    logic               halt_req_q, halt_req_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               xfer;
    logic [DATA_W-1:0]  shifted;
    logic [7:0]         csum_next;

    assign xfer      = tx_valid_q & tx_ready;
    assign shifted   = shift_q >> 8;
    assign csum_next = csum_q + tx_data_q;

    // Next-state and next-output computation; every output is registered from these.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HALT;
                    idx_d   = '0;   // keeps ra parked at 0 while waiting for the halt ack
                    csum_d  = '0;
                end
            end
            S_HALT: begin
                if (halted) begin
                    state_d    = S_HDR;
                    tx_valid_d = 1'b1;
                    tx_data_d  = HDR_BYTE;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    state_d    = S_LOAD;
                    idx_d      = '0;
                    csum_d     = '0;
                    tx_valid_d = 1'b0;
                end
            end
            S_LOAD: begin
                // ra has been stable since the previous edge, so rd is settled here.
                shift_d    = rd;
                tx_data_d  = rd[7:0];
                byte_cnt_d = '0;
                tx_valid_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (xfer) begin
                    csum_d = csum_next;
                    if (byte_cnt_q != LAST_BYTE) begin
                        shift_d    = shifted;
                        tx_data_d  = shifted[7:0];
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end else if (idx_q != LAST_IDX) begin
                        idx_d      = idx_q + IDX_W'(1);
                        tx_valid_d = 1'b0;
                        state_d    = S_LOAD;
                    end else begin
                        // Checksum byte already includes the byte just accepted.
                        tx_data_d = csum_next;
                        state_d   = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // Status outputs follow the state being entered so they are registered alongside it.
    assign halt_req_d = (state_d != S_IDLE) && (state_d != S_DONE);
    assign busy_d     = (state_d != S_IDLE);
    assign done_d     = (state_d == S_DONE);

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
            halt_req_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            halt_req_q <= halt_req_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ra       = idx_q;
    assign halt_req = halt_req_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
